// File: rtl/biasregb_mb_pkg.sv
// Shared definitions for the multi-bank bias register buffer: bank ownership
// states, the read-pipeline depth and the protocol-error codes.
package biasregb_mb_pkg;

    typedef enum logic [1:0] {
        BRB_FREE    = 2'd0,
        BRB_LOADING = 2'd1,
        BRB_READY   = 2'd2
    } bank_state_e;

    localparam int BRB_RD_DLY = 3;

    localparam logic [1:0] BRB_ERR_NONE      = 2'd0;
    localparam logic [1:0] BRB_ERR_WR_READY  = 2'd1;
    localparam logic [1:0] BRB_ERR_RD_NREADY = 2'd2;
    localparam logic [1:0] BRB_ERR_BAD_REL   = 2'd3;

    // Code of the highest-priority error raised in one cycle.
    function automatic logic [1:0] brb_first_err(input logic wr_err,
                                                 input logic rd_err,
                                                 input logic rel_err);
        logic [1:0] code;
        if (wr_err) begin
            code = BRB_ERR_WR_READY;
        end else if (rd_err) begin
            code = BRB_ERR_RD_NREADY;
        end else if (rel_err) begin
            code = BRB_ERR_BAD_REL;
        end else begin
            code = BRB_ERR_NONE;
        end
        return code;
    endfunction

    // Number of error events raised in one cycle (0..3).
    function automatic logic [1:0] brb_err_events(input logic wr_err,
                                                  input logic rd_err,
                                                  input logic rel_err);
        return {1'b0, wr_err} + {1'b0, rd_err} + {1'b0, rel_err};
    endfunction

endpackage

// File: rtl/brb_sdp_ram.sv
// Behavioural simple-dual-port RAM with byte-enable writes and a registered
// read port; contents are not reset. Can be swapped for a vendor macro wrapper.
module brb_sdp_ram #(
    parameter int AW = 10,
    parameter int DW = 64,
    parameter int SW = DW / 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [SW-1:0] wstrb,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [2**AW];
    logic [DW-1:0] rdata_r;

    // Byte-strobed write port; unstrobed bytes keep their old contents
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < SW; b++) begin
                if (wstrb[b]) begin
                    mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Registered read port, updated only on an enabled read
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/biasregb_mb.sv
// Multi-bank bias register buffer: per-bank FREE/LOADING/READY handshake between
// loader and VPU, 3-cycle read pipeline, sticky error. Optional BIASREGB_MB_ERR_CNT_EN
// adds a saturating error counter and first-error code.
module biasregb_mb
    import biasregb_mb_pkg::*;
#(
    parameter int BR_IND_WTH  = 1,
    parameter int BR_ADDR_WTH = 9,
    parameter int BR_DATA_WTH = 64,
    parameter int BR_STRB_WTH = BR_DATA_WTH / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [BR_IND_WTH-1:0]      ldmr_brb__windex_i,
    input  logic [BR_ADDR_WTH-1:0]     ldmr_brb__waddr_i,
    input  logic                       ldmr_brb__we_i,
    input  logic [BR_DATA_WTH-1:0]     ldmr_brb__wdata_i,
    input  logic [BR_STRB_WTH-1:0]     ldmr_brb__wstrb_i,
    input  logic                       ldmr_brb__wlast_i,
    output logic [(2**BR_IND_WTH)-1:0] brb_ldmr__bank_free_o,
    input  logic [BR_IND_WTH-1:0]      vpu_brb__rindex_i,
    input  logic [BR_ADDR_WTH-1:0]     vpu_brb__raddr_i,
    input  logic                       vpu_brb__re_i,
    input  logic                       vpu_brb__release_i,
    output logic [(2**BR_IND_WTH)-1:0] brb_vpu__bank_rdy_o,
    output logic [BR_DATA_WTH-1:0]     vpu_brb__rdata_o,
    output logic                       vpu_brb__rdata_act_o,
    output logic                       brb__err_o
`ifdef BIASREGB_MB_ERR_CNT_EN
    ,
    output logic [15:0]                brb__err_cnt_o,
    output logic [1:0]                 brb__err_code_o
`endif
);

    localparam int NB  = 2 ** BR_IND_WTH;
    localparam int RAW = BR_IND_WTH + BR_ADDR_WTH;

    bank_state_e            state_r     [NB];
    bank_state_e            state_nxt_s [NB];
    bank_state_e            wr_tgt_s;
    bank_state_e            rd_tgt_s;
    logic                   wr_ok_s;
    logic                   wr_err_s;
    logic                   rd_ok_s;
    logic                   rd_err_s;
    logic                   rel_ok_s;
    logic                   rel_err_s;
    logic [NB-1:0]          free_nxt_s;
    logic [NB-1:0]          rdy_nxt_s;
    logic [NB-1:0]          bank_free_r;
    logic [NB-1:0]          bank_rdy_r;

    logic                   wr_vld_r;
    logic [RAW-1:0]         wr_addr_r;
    logic [BR_DATA_WTH-1:0] wr_data_r;
    logic [BR_STRB_WTH-1:0] wr_strb_r;

    logic [BRB_RD_DLY-1:0]  rd_pipe_r;
    logic [RAW-1:0]         rd_addr_r;
    logic [BR_DATA_WTH-1:0] ram_rdata_s;
    logic [BR_DATA_WTH-1:0] rdata_r;
    logic                   err_r;

    // Classify this cycle's requests against the bank states at the request
    always_comb begin
        wr_tgt_s  = state_r[ldmr_brb__windex_i];
        rd_tgt_s  = state_r[vpu_brb__rindex_i];
        wr_ok_s   = ldmr_brb__we_i & (wr_tgt_s != BRB_READY);
        wr_err_s  = ldmr_brb__we_i & (wr_tgt_s == BRB_READY);
        rd_ok_s   = vpu_brb__re_i & (rd_tgt_s == BRB_READY);
        rd_err_s  = vpu_brb__re_i & (rd_tgt_s != BRB_READY);
        rel_ok_s  = vpu_brb__release_i & (rd_tgt_s == BRB_READY);
        rel_err_s = vpu_brb__release_i & (rd_tgt_s != BRB_READY);
    end

    // Per-bank ownership FSM next state; write and release can never hit one bank
    always_comb begin
        free_nxt_s = '0;
        rdy_nxt_s  = '0;
        for (int b = 0; b < NB; b++) begin
            state_nxt_s[b] = state_r[b];
            case (state_r[b])
                BRB_FREE, BRB_LOADING: begin
                    if (wr_ok_s && (ldmr_brb__windex_i == BR_IND_WTH'(b))) begin
                        if (ldmr_brb__wlast_i) begin
                            state_nxt_s[b] = BRB_READY;
                        end else begin
                            state_nxt_s[b] = BRB_LOADING;
                        end
                    end else begin
                        state_nxt_s[b] = state_r[b];
                    end
                end
                BRB_READY: begin
                    if (rel_ok_s && (vpu_brb__rindex_i == BR_IND_WTH'(b))) begin
                        state_nxt_s[b] = BRB_FREE;
                    end else begin
                        state_nxt_s[b] = BRB_READY;
                    end
                end
                default: state_nxt_s[b] = BRB_FREE;
            endcase
            free_nxt_s[b] = (state_nxt_s[b] == BRB_FREE);
            rdy_nxt_s[b]  = (state_nxt_s[b] == BRB_READY);
        end
    end

    // Bank state registers and the status vectors decoded from them
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < NB; b++) begin
                state_r[b] <= BRB_FREE;
            end
            bank_free_r <= '1;
            bank_rdy_r  <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                state_r[b] <= state_nxt_s[b];
            end
            bank_free_r <= free_nxt_s;
            bank_rdy_r  <= rdy_nxt_s;
        end
    end

    // Accepted write is staged one cycle before it reaches the RAM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_vld_r  <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            wr_strb_r <= '0;
        end else begin
            wr_vld_r <= wr_ok_s;
            if (wr_ok_s) begin
                wr_addr_r <= {ldmr_brb__windex_i, ldmr_brb__waddr_i};
                wr_data_r <= ldmr_brb__wdata_i;
                wr_strb_r <= ldmr_brb__wstrb_i;
            end
        end
    end

    // Read pipeline: request register, RAM read, output register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_pipe_r <= '0;
            rd_addr_r <= '0;
            rdata_r   <= '0;
        end else begin
            rd_pipe_r <= {rd_pipe_r[BRB_RD_DLY-2:0], rd_ok_s};
            if (rd_ok_s) begin
                rd_addr_r <= {vpu_brb__rindex_i, vpu_brb__raddr_i};
            end
            if (rd_pipe_r[1]) begin
                rdata_r <= ram_rdata_s;
            end
        end
    end

    // Sticky protocol-error flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | wr_err_s | rd_err_s | rel_err_s;
        end
    end

    brb_sdp_ram #(
        .AW (RAW),
        .DW (BR_DATA_WTH),
        .SW (BR_STRB_WTH)
    ) u_ram (
        .clk   (clk_i),
        .we    (wr_vld_r),
        .waddr (wr_addr_r),
        .wdata (wr_data_r),
        .wstrb (wr_strb_r),
        .re    (rd_pipe_r[0]),
        .raddr (rd_addr_r),
        .rdata (ram_rdata_s)
    );

    assign brb_ldmr__bank_free_o = bank_free_r;
    assign brb_vpu__bank_rdy_o   = bank_rdy_r;
    assign vpu_brb__rdata_o      = rdata_r;
    assign vpu_brb__rdata_act_o  = rd_pipe_r[BRB_RD_DLY-1];
    assign brb__err_o            = err_r;

`ifdef BIASREGB_MB_ERR_CNT_EN
    logic [15:0] err_cnt_r;
    logic [1:0]  err_code_r;
    logic [16:0] err_sum_s;

    assign err_sum_s = {1'b0, err_cnt_r} + {15'd0, brb_err_events(wr_err_s, rd_err_s, rel_err_s)};

    // Saturating error count and first-error code capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_r  <= 16'd0;
            err_code_r <= BRB_ERR_NONE;
        end else begin
            if (err_sum_s[16]) begin
                err_cnt_r <= 16'hFFFF;
            end else begin
                err_cnt_r <= err_sum_s[15:0];
            end
            if (err_code_r == BRB_ERR_NONE) begin
                err_code_r <= brb_first_err(wr_err_s, rd_err_s, rel_err_s);
            end
        end
    end

    assign brb__err_cnt_o  = err_cnt_r;
    assign brb__err_code_o = err_code_r;
`endif

endmodule

// File: tb/tb_biasregb_mb.sv
// Self-checking bench for biasregb_mb: directed vectors, a bank-level model with a
// read-return queue, and a per-cycle compare process.
module tb_biasregb_mb;

    localparam int IW = 1;
    localparam int AW = 9;
    localparam int DW = 64;
    localparam int SW = 8;
    localparam int NB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] windex;
    logic [AW-1:0] waddr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast;
    logic [NB-1:0] bank_free;
    logic [IW-1:0] rindex;
    logic [AW-1:0] raddr;
    logic          re;
    logic          rel;
    logic [NB-1:0] bank_rdy;
    logic [DW-1:0] rdata;
    logic          rdata_act;
    logic          err;
`ifdef BIASREGB_MB_ERR_CNT_EN
    logic [15:0]   err_cnt;
    logic [1:0]    err_code;
`endif

    typedef struct {
        int          due;
        logic [63:0] data;
    } rd_exp_t;

    rd_exp_t     exp_q[$];
    logic [63:0] mdl_mem [NB][512];
    int          mdl_st  [NB];   // 0 free, 1 loading, 2 ready
    bit          mdl_err;
    int          mdl_cnt;
    int          mdl_code;
    logic [63:0] last_dat;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_mis = 0;
    bit          run_cmp = 1'b0;
    int          cur_run = 0;
    int          max_run = 0;
    bit          exp_act;
    logic [63:0] exp_dat;
    logic [NB-1:0] exp_free;
    logic [NB-1:0] exp_rdy;

    biasregb_mb dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .ldmr_brb__windex_i    (windex),
        .ldmr_brb__waddr_i     (waddr),
        .ldmr_brb__we_i        (we),
        .ldmr_brb__wdata_i     (wdata),
        .ldmr_brb__wstrb_i     (wstrb),
        .ldmr_brb__wlast_i     (wlast),
        .brb_ldmr__bank_free_o (bank_free),
        .vpu_brb__rindex_i     (rindex),
        .vpu_brb__raddr_i      (raddr),
        .vpu_brb__re_i         (re),
        .vpu_brb__release_i    (rel),
        .brb_vpu__bank_rdy_o   (bank_rdy),
        .vpu_brb__rdata_o      (rdata),
        .vpu_brb__rdata_act_o  (rdata_act),
        .brb__err_o            (err)
`ifdef BIASREGB_MB_ERR_CNT_EN
        ,
        .brb__err_cnt_o        (err_cnt),
        .brb__err_code_o       (err_code)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int a, input bit inv);
        logic [63:0] v;
        v = {16'hB1A5, 16'(a), 16'h5A5A ^ 16'(a), 16'hC3C3};
        return inv ? ~v : v;
    endfunction

    task automatic mdl_reset();
        for (int b = 0; b < NB; b++) mdl_st[b] = 0;
        mdl_err  = 1'b0;
        mdl_cnt  = 0;
        mdl_code = 0;
        last_dat = 64'd0;
        exp_q.delete();
    endtask

    // One clock of stimulus; the model applies the spec rules to the pre-edge bank states.
    task automatic step(input bit w, input int wb, input int wa, input logic [63:0] wd,
                        input logic [7:0] ws, input bit wl,
                        input bit r, input int rb, input int ra, input bit rl);
        int n;
        int sw;
        int sr;
        bit e1;
        bit e2;
        bit e3;
        we = w; windex = IW'(wb); waddr = AW'(wa); wdata = wd; wstrb = ws; wlast = wl;
        re = r; rindex = IW'(rb); raddr = AW'(ra); rel = rl;
        n = cyc;
        @(posedge clk);
        sw = mdl_st[wb];
        sr = mdl_st[rb];
        e1 = w && (sw == 2);
        e2 = r && (sr != 2);
        e3 = rl && (sr != 2);
        if (w && sw != 2) begin
            for (int b = 0; b < 8; b++) if (ws[b]) mdl_mem[wb][wa][b*8 +: 8] = wd[b*8 +: 8];
            mdl_st[wb] = wl ? 2 : 1;
        end
        if (r && sr == 2) exp_q.push_back('{n + 3, mdl_mem[rb][ra]});
        if (rl && sr == 2) mdl_st[rb] = 0;
        if (e1 || e2 || e3) mdl_err = 1'b1;
        mdl_cnt = mdl_cnt + int'(e1) + int'(e2) + int'(e3);
        if (mdl_cnt > 65535) mdl_cnt = 65535;
        if (mdl_code == 0) mdl_code = e1 ? 1 : (e2 ? 2 : (e3 ? 3 : 0));
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) step(0, 0, 0, 64'd0, 8'h00, 0, 0, 0, 0, 0);
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (run_cmp) begin
            exp_act = 1'b0;
            exp_dat = last_dat;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_act  = 1'b1;
                exp_dat  = exp_q[0].data;
                last_dat = exp_dat;
                void'(exp_q.pop_front());
            end
            for (int b = 0; b < NB; b++) begin
                exp_free[b] = (mdl_st[b] == 0);
                exp_rdy[b]  = (mdl_st[b] == 2);
            end
            chk("rdata_act", 64'(rdata_act), 64'(exp_act));
            chk("rdata", rdata, exp_dat);
            chk("bank_free", 64'(bank_free), 64'(exp_free));
            chk("bank_rdy", 64'(bank_rdy), 64'(exp_rdy));
            chk("err", 64'(err), 64'(mdl_err));
`ifdef BIASREGB_MB_ERR_CNT_EN
            chk("err_cnt", 64'(err_cnt), 64'(mdl_cnt));
            chk("err_code", 64'(err_code), 64'(mdl_code));
`endif
            if (rdata_act) cur_run++;
            else cur_run = 0;
            if (cur_run > max_run) max_run = cur_run;
        end
    end

    initial begin
        rst = 1'b1;
        we = 1'b0; windex = '0; waddr = '0; wdata = '0; wstrb = '0; wlast = 1'b0;
        re = 1'b0; rindex = '0; raddr = '0; rel = 1'b0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_free", 64'(bank_free), 64'h3);
        chk("rst_rdy", 64'(bank_rdy), 64'h0);
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_act", 64'(rdata_act), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        rst = 1'b0;
        run_cmp = 1'b1;
        idle(2);

        // Single-bank load: bank0 addr0..3 = 0x11..0x44, wlast on addr3
        for (int a = 0; a < 4; a++) step(1, 0, a, 64'(8'h11 * (a + 1)), 8'hFF, a == 3, 0, 0, 0, 0);
        chk("load_rdy", 64'(bank_rdy), 64'h1);
        chk("load_free", 64'(bank_free), 64'h2);
        step(0, 0, 0, 64'd0, 8'h00, 0, 1, 0, 2, 0);
        idle(2);
        @(negedge clk);
        chk("rd2_act", 64'(rdata_act), 64'h1);
        chk("rd2_data", rdata, 64'h33);
        step(0, 0, 0, 64'd0, 8'h00, 0, 0, 0, 0, 1);

        // Full bank0 load, then 512 back-to-back reads while bank1 loads
        for (int a = 0; a < 512; a++) step(1, 0, a, pat(a, 0), 8'hFF, a == 511, 0, 0, 0, 0);
        for (int i = 0; i < 512; i++) begin
            if (i < 16)       step(1, 1, i,  pat(i, 1), 8'hFF, 0, 1, 0, i, 0);
            else if (i == 16) step(1, 1, 20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1, 0, i, 0);
            else if (i == 17) step(1, 1, 20, 64'h0, 8'h0F, 1, 1, 0, i, 0);
            else              step(0, 0, 0,  64'd0, 8'h00, 0, 1, 0, i, 0);
        end
        idle(4);
        chk("pp_run", 64'(max_run), 64'd512);
        chk("pp_rdy", 64'(bank_rdy), 64'h3);

        // Byte strobe readback
        step(0, 0, 0, 64'd0, 8'h00, 0, 1, 1, 20, 0);
        idle(2);
        @(negedge clk);
        chk("strb_data", rdata, 64'hFFFF_FFFF_0000_0000);

        // Protocol errors: read FREE, write READY, release LOADING
        step(0, 0, 0, 64'd0, 8'h00, 0, 0, 1, 0, 1);
        step(0, 0, 0, 64'd0, 8'h00, 0, 1, 1, 0, 0);
        step(1, 0, 5, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, 0, 0, 0, 0);
        step(1, 1, 0, pat(0, 1), 8'hFF, 0, 0, 0, 0, 0);
        step(0, 0, 0, 64'd0, 8'h00, 0, 0, 1, 0, 1);
        idle(4);
        chk("perr_err", 64'(err), 64'h1);
`ifdef BIASREGB_MB_ERR_CNT_EN
        chk("perr_cnt", 64'(err_cnt), 64'd3);
        chk("perr_code", 64'(err_code), 64'd2);
`endif
        step(0, 0, 0, 64'd0, 8'h00, 0, 1, 0, 5, 0);
        idle(2);
        @(negedge clk);
        chk("perr_keep", rdata, pat(5, 0));
        step(1, 1, 0, pat(0, 1), 8'hFF, 1, 0, 0, 0, 0);

        // Release race: read and release bank0 together
        step(0, 0, 0, 64'd0, 8'h00, 0, 1, 0, 7, 1);
        chk("race_free0", 64'(bank_free[0]), 64'h1);
        idle(2);
        @(negedge clk);
        chk("race_act", 64'(rdata_act), 64'h1);
        chk("race_data", rdata, pat(7, 0));

        // Async reset mid-load with two reads in flight
        step(1, 0, 0, pat(0, 0), 8'hFF, 0, 1, 1, 0, 0);
        step(1, 0, 1, pat(1, 0), 8'hFF, 0, 1, 1, 1, 0);
        rst = 1'b1;
        mdl_reset();
        #1;
        chk("arst_rdata", rdata, 64'h0);
        chk("arst_act", 64'(rdata_act), 64'h0);
        chk("arst_free", 64'(bank_free), 64'h3);
        chk("arst_rdy", 64'(bank_rdy), 64'h0);
        chk("arst_err", 64'(err), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);
        chk("post_free", 64'(bank_free), 64'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
